// File: rtl/keypad_id_buffer_if.sv
// Keypad-to-comparator bus: scanner strobes in, accumulated ID and status out.
interface keypad_id_buffer_if #(
    parameter int unsigned DIGITS = 10
);
    logic                  key_valid;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   registro;
    logic [3:0]            digit_count;
    logic                  entry_ready;
    logic                  entry_done;
    logic                  entry_error;
    logic                  timeout;

    // Scanner / comparison-stage side
    modport master (
        output key_valid, key_code,
        input  registro, digit_count, entry_ready, entry_done, entry_error, timeout
    );

    // ID buffer side
    modport slave (
        input  key_valid, key_code,
        output registro, digit_count, entry_ready, entry_done, entry_error, timeout
    );
endinterface

// File: rtl/keypad_id_buffer.sv
// Accumulates keypad digits into a BCD identity, with clear/enter keys and inactivity timeout.
module keypad_id_buffer #(
    parameter int unsigned DIGITS         = 10,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned TMR_W          = 29
) (
    input  logic                clk,
    input  logic                rst,
    keypad_id_buffer_if.slave   bus
);
    localparam int unsigned      RW         = 4 * DIGITS;
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       CNT_LAST   = 4'(DIGITS - 1);
    localparam logic [3:0]       CODE_CLEAR = 4'hA;
    localparam logic [3:0]       CODE_ENTER = 4'hB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     registro_q, registro_d;
    logic [3:0]        count_q, count_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              timeout_q, timeout_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              is_digit, is_clear, is_enter, key_hit, timed, expire;
    logic [RW-1:0]     shifted;

    // Key decode; unused codes 0xC-0xF never count as a press
    assign is_digit = bus.key_valid && (bus.key_code <= 4'd9);
    assign is_clear = bus.key_valid && (bus.key_code == CODE_CLEAR);
    assign is_enter = bus.key_valid && (bus.key_code == CODE_ENTER);
    assign key_hit  = is_digit || is_clear || is_enter;
    assign timed    = (state_q == ENTRY) || (state_q == FULL);
    // A key arriving on the terminal count wins over the timeout
    assign expire   = timed && !key_hit && (timer_q == TMR_LAST);
    // Truncation drops the oldest nibble and appends the new digit at the LS end
    assign shifted  = RW'({registro_q, bus.key_code});

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            registro_q <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            timeout_q  <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            registro_q <= registro_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            timeout_q  <= timeout_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (is_digit) state_d = (DIGITS == 1) ? FULL : ENTRY;
            end
            ENTRY: begin
                if (is_digit && (count_q == CNT_LAST)) state_d = FULL;
                else if (is_clear || expire)           state_d = IDLE;
            end
            FULL: begin
                if (is_enter)                 state_d = DONE;
                else if (is_clear || expire)  state_d = IDLE;
            end
            DONE: begin
                if (is_clear)      state_d = IDLE;
                else if (is_digit) state_d = (DIGITS == 1) ? FULL : ENTRY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the inactivity timer
    always_comb begin
        registro_d = registro_q;
        count_d    = count_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        timeout_d  = 1'b0;
        ready_d    = (state_d == DONE);
        timer_d    = '0;

        case (state_q)
            IDLE: begin
                if (is_digit) begin
                    registro_d = shifted;
                    count_d    = 4'(count_q + 4'd1);
                end else if (is_enter) begin
                    error_d = 1'b1;
                end
            end
            ENTRY: begin
                if (is_digit) begin
                    registro_d = shifted;
                    count_d    = 4'(count_q + 4'd1);
                end else if (is_clear || expire) begin
                    registro_d = '0;
                    count_d    = '0;
                    timeout_d  = expire;
                end else if (is_enter) begin
                    error_d = 1'b1;
                end
            end
            FULL: begin
                if (is_digit) begin
                    error_d = 1'b1;
                end else if (is_enter) begin
                    done_d = 1'b1;
                end else if (is_clear || expire) begin
                    registro_d = '0;
                    count_d    = '0;
                    timeout_d  = expire;
                end
            end
            DONE: begin
                if (is_clear) begin
                    registro_d = '0;
                    count_d    = '0;
                end else if (is_digit) begin
                    registro_d = RW'(bus.key_code);
                    count_d    = 4'd1;
                end
            end
            default: begin
                registro_d = '0;
                count_d    = '0;
            end
        endcase

        if (timed && (state_d == state_q) && !key_hit) begin
            timer_d = TMR_W'(timer_q + 1'b1);
        end
    end

    assign bus.registro    = registro_q;
    assign bus.digit_count = count_q;
    assign bus.entry_ready = ready_q;
    assign bus.entry_done  = done_q;
    assign bus.entry_error = error_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_keypad_id_buffer.sv
// Directed bench for keypad_id_buffer (10 digits, 20-cycle timeout).
module tb_keypad_id_buffer;
    localparam int unsigned DIGITS = 10;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    keypad_id_buffer_if #(.DIGITS(DIGITS)) bus ();

    keypad_id_buffer #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (20),
        .TMR_W          (29)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One key strobe; returns 1 time unit after the edge that sampled it
    task automatic press(input logic [3:0] code);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        repeat (2) idle_cycle();
        rst = 1'b1;
        idle_cycle();
        total_cnt++;
        if (bus.registro !== 40'h0) $display("FAIL reset_registro: got %h expected %h", bus.registro, 40'h0);
        else pass_cnt++;
        total_cnt++;
        if (bus.digit_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", bus.digit_count);
        else pass_cnt++;
        total_cnt++;
        if ({bus.entry_ready, bus.entry_done, bus.entry_error, bus.timeout} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.entry_ready, bus.entry_done, bus.entry_error, bus.timeout});
        else pass_cnt++;
    endtask

    task automatic test_full_entry();
        logic [3:0] keys [10] = '{4'h1, 4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        int tmo_seen = 0;
        foreach (keys[i]) press(keys[i]);
        total_cnt++;
        if (bus.registro !== 40'h1023456789 || bus.digit_count !== 4'd10)
            $display("FAIL full_before_enter: got %h/%0d expected 1023456789/10", bus.registro, bus.digit_count);
        else pass_cnt++;
        press(4'hB);
        total_cnt++;
        if (bus.entry_done !== 1'b1 || bus.entry_ready !== 1'b1)
            $display("FAIL full_done_pulse: got done=%b ready=%b expected 1/1", bus.entry_done, bus.entry_ready);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (bus.entry_done !== 1'b0 || bus.entry_ready !== 1'b1)
            $display("FAIL full_done_width: got done=%b ready=%b expected 0/1", bus.entry_done, bus.entry_ready);
        else pass_cnt++;
        press(4'hB);
        total_cnt++;
        if (bus.entry_done !== 1'b0 || bus.entry_error !== 1'b0)
            $display("FAIL done_enter_ignored: got done=%b err=%b expected 0/0", bus.entry_done, bus.entry_error);
        else pass_cnt++;
        repeat (30) begin
            idle_cycle();
            if (bus.timeout !== 1'b0) tmo_seen++;
        end
        total_cnt++;
        if (tmo_seen != 0 || bus.entry_ready !== 1'b1 || bus.registro !== 40'h1023456789)
            $display("FAIL done_stable: got tmo=%0d ready=%b reg=%h expected 0/1/1023456789",
                     tmo_seen, bus.entry_ready, bus.registro);
        else pass_cnt++;
    endtask

    task automatic test_short_entry();
        press(4'hA);
        total_cnt++;
        if (bus.registro !== 40'h0 || bus.digit_count !== 4'd0 || bus.entry_ready !== 1'b0)
            $display("FAIL done_clear: got %h/%0d/%b expected 0/0/0", bus.registro, bus.digit_count, bus.entry_ready);
        else pass_cnt++;
        press(4'h5); press(4'h5); press(4'h5);
        press(4'hB);
        total_cnt++;
        if (bus.entry_error !== 1'b1 || bus.registro !== 40'h555 || bus.digit_count !== 4'd3 || bus.entry_ready !== 1'b0)
            $display("FAIL short_enter: got err=%b reg=%h cnt=%0d ready=%b expected 1/555/3/0",
                     bus.entry_error, bus.registro, bus.digit_count, bus.entry_ready);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (bus.entry_error !== 1'b0) $display("FAIL short_error_width: got %b expected 0", bus.entry_error);
        else pass_cnt++;
        press(4'hA);
        total_cnt++;
        if (bus.registro !== 40'h0 || bus.digit_count !== 4'd0)
            $display("FAIL short_clear: got %h/%0d expected 0/0", bus.registro, bus.digit_count);
        else pass_cnt++;
        press(4'hB);
        total_cnt++;
        if (bus.entry_error !== 1'b1 || bus.digit_count !== 4'd0)
            $display("FAIL idle_enter_error: got err=%b cnt=%0d expected 1/0", bus.entry_error, bus.digit_count);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [3:0] keys [10] = '{4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
        foreach (keys[i]) press(keys[i]);
        press(4'h7);
        total_cnt++;
        if (bus.entry_error !== 1'b1 || bus.registro !== 40'h9876543210 || bus.digit_count !== 4'd10)
            $display("FAIL overflow_digit: got err=%b reg=%h cnt=%0d expected 1/9876543210/10",
                     bus.entry_error, bus.registro, bus.digit_count);
        else pass_cnt++;
        press(4'hB);
        total_cnt++;
        if (bus.entry_done !== 1'b1 || bus.registro !== 40'h9876543210)
            $display("FAIL overflow_enter: got done=%b reg=%h expected 1/9876543210", bus.entry_done, bus.registro);
        else pass_cnt++;
    endtask

    task automatic test_done_restart();
        logic [3:0] keys [10] = '{4'h1, 4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
        press(4'hA);
        foreach (keys[i]) press(keys[i]);
        press(4'hB);
        press(4'h4);
        total_cnt++;
        if (bus.registro !== 40'h4 || bus.digit_count !== 4'd1 || bus.entry_ready !== 1'b0 || bus.entry_done !== 1'b0)
            $display("FAIL done_restart: got reg=%h cnt=%0d ready=%b done=%b expected 4/1/0/0",
                     bus.registro, bus.digit_count, bus.entry_ready, bus.entry_done);
        else pass_cnt++;
        press(4'hA);
        press(4'hC);
        total_cnt++;
        if (bus.registro !== 40'h0 || bus.digit_count !== 4'd0 || bus.entry_error !== 1'b0)
            $display("FAIL idle_unused: got reg=%h cnt=%0d err=%b expected 0/0/0",
                     bus.registro, bus.digit_count, bus.entry_error);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int early;
        // Plain expiry 20 cycles after the last digit
        press(4'h9); press(4'h8);
        early = 0;
        for (int k = 1; k < 20; k++) begin
            idle_cycle();
            if (bus.timeout !== 1'b0 || bus.registro !== 40'h98) early++;
        end
        total_cnt++;
        if (early != 0) $display("FAIL timeout_early: got %0d bad cycles expected 0", early);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (bus.timeout !== 1'b1 || bus.registro !== 40'h0 || bus.digit_count !== 4'd0)
            $display("FAIL timeout_fire: got tmo=%b reg=%h cnt=%0d expected 1/0/0",
                     bus.timeout, bus.registro, bus.digit_count);
        else pass_cnt++;
        idle_cycle();
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL timeout_width: got %b expected 0", bus.timeout);
        else pass_cnt++;

        // Key on the terminal cycle wins
        press(4'h9); press(4'h8);
        early = 0;
        for (int k = 1; k < 20; k++) begin
            idle_cycle();
            if (bus.timeout !== 1'b0) early++;
        end
        press(4'h3);
        total_cnt++;
        if (early != 0 || bus.timeout !== 1'b0 || bus.registro !== 40'h983 || bus.digit_count !== 4'd3)
            $display("FAIL timeout_key_wins: got early=%0d tmo=%b reg=%h cnt=%0d expected 0/0/983/3",
                     early, bus.timeout, bus.registro, bus.digit_count);
        else pass_cnt++;
        early = 0;
        for (int k = 1; k < 20; k++) begin
            idle_cycle();
            if (bus.timeout !== 1'b0) early++;
        end
        idle_cycle();
        total_cnt++;
        if (early != 0 || bus.timeout !== 1'b1)
            $display("FAIL timeout_restart: got early=%0d tmo=%b expected 0/1", early, bus.timeout);
        else pass_cnt++;

        // Unused code mid-entry does not restart the timer
        press(4'h9);
        for (int k = 1; k < 10; k++) idle_cycle();
        press(4'hC);
        total_cnt++;
        if (bus.entry_error !== 1'b0 || bus.registro !== 40'h9)
            $display("FAIL entry_unused: got err=%b reg=%h expected 0/9", bus.entry_error, bus.registro);
        else pass_cnt++;
        for (int k = 11; k < 20; k++) idle_cycle();
        idle_cycle();
        total_cnt++;
        if (bus.timeout !== 1'b1 || bus.registro !== 40'h0)
            $display("FAIL unused_no_restart: got tmo=%b reg=%h expected 1/0", bus.timeout, bus.registro);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        press(4'h1); press(4'h2);
        @(negedge clk);
        rst = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        total_cnt++;
        if (bus.registro !== 40'h0 || bus.digit_count !== 4'd0 ||
            {bus.entry_ready, bus.entry_done, bus.entry_error, bus.timeout} !== 4'b0000)
            $display("FAIL reset_mid: got reg=%h cnt=%0d flags=%b expected 0/0/0000", bus.registro, bus.digit_count,
                     {bus.entry_ready, bus.entry_done, bus.entry_error, bus.timeout});
        else pass_cnt++;
        press(4'h6);
        total_cnt++;
        if (bus.registro !== 40'h6 || bus.digit_count !== 4'd1)
            $display("FAIL reset_mid_resume: got %h/%0d expected 6/1", bus.registro, bus.digit_count);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_full_entry();
        test_short_entry();
        test_overflow();
        test_done_restart();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
